// File: rtl/sprite_register_writer.sv
// sprite_register_writer: buffers sprite/background register writes in a
// small FIFO and commits them one per clk only while the print path is idle.
// Ports: clk, reset (async, active low); wr_en/wr_reg/wr_data/wr_ready
// write offer; printtingScreen blocks commits; rd_addr -> data_reg (1 clk);
// pending = buffered writes; overflow = sticky dropped-write flag.
module sprite_register_writer #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_BITS  = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [ADDR_BITS-1:0]          wr_reg,
  input  logic [31:0]                   wr_data,
  output logic                          wr_ready,
  input  logic                          printtingScreen,
  input  logic [ADDR_BITS-1:0]          rd_addr,
  output logic [31:0]                   data_reg,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_BITS:0] NREGS = (ADDR_BITS+1)'(NUM_REGS);

  typedef struct packed {
    logic [ADDR_BITS-1:0] idx;
    logic [31:0]          data;
  } wr_req_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    COMMIT
  } state_t;

  state_t        state;
  state_t        state_next;
  wr_req_t       fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_next;
  logic [31:0]   regs [NUM_REGS];
  logic          push;
  logic          pop;
  wr_req_t       head;
  logic          head_ok;
  logic          rd_ok;

  // Full is judged on the current count only, so a commit in the
  // same cycle never lets a full buffer take another write.
  assign wr_ready = (count != FULL);
  assign pending  = count;
  assign head     = fifo[rd_ptr];
  assign head_ok  = {1'b0, head.idx} < NREGS;
  assign rd_ok    = {1'b0, rd_addr} < NREGS;

  always_comb begin
    push       = wr_en && wr_ready;
    pop        = (state == COMMIT);
    count_next = count;
    state_next = state;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (!push && pop) begin
      count_next = count - 1'b1;
    end
    // Decided on the post-edge occupancy, so COMMIT always has an entry.
    unique case (1'b1)
      (count_next == '0):
        state_next = IDLE;
      (count_next != '0) && printtingScreen:
        state_next = HOLD;
      (count_next != '0) && !printtingScreen:
        state_next = COMMIT;
      default:
        state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo[i] <= '0;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_reg <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= {wr_reg, wr_data};
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (wr_en && !wr_ready) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Out-of-range targets are consumed without touching the array.
      if (pop && head_ok) begin
        regs[head.idx] <= head.data;
      end
      count <= count_next;
      // Samples the pre-commit value on a same-index commit edge.
      data_reg <= rd_ok ? regs[rd_addr] : '0;
    end
  end

endmodule
